clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Run-time controller for the system clock divider. It generates the divided clock (clk_out) and single-cycle phase ticks from clk_in. A host loads divide ratios through a valid/ready config port, and the block applies them only at period boundaries, so clk_out never glitches. It also sequences clean start/stop of the divided clock. The I2C slave timing logic uses it in place of a fixed-ratio divider.

Parameters:
CNT_W, 16, width of divisor and period counter
DEF_DIV, 270, divisor loaded at reset (must be >= MIN_DIV and < 2^CNT_W)
MIN_DIV, 2, smallest accepted divisor

Ports:
clk_in  input  1  system clock
reset  input  1  synchronous, active-high reset
run  input  1  level: 1 = divided clock requested, 0 = stop at next period end
cfg_valid  input  1  host offers new divisor
cfg_div  input  CNT_W  requested divisor
cfg_ready  output  1  1 = no divisor pending; offer may be accepted
cfg_err  output  1  one-cycle pulse: offered divisor rejected
clk_out  output  1  divided clock, registered
rise_tick  output  1  one-cycle pulse in the first high cycle of each period
fall_tick  output  1  one-cycle pulse in the first low cycle of each period
active  output  1  1 while state is RUN or STOP_PEND
cur_div  output  CNT_W  divisor currently in effect

Behaviour:
- Reset values: state IDLE, cnt=0, div_act=DEF_DIV, pend_valid=0. Outputs: clk_out=0, rise_tick=0, fall_tick=0, cfg_err=0, active=0, cfg_ready=1, cur_div=DEF_DIV.
- Reset asserted mid-operation forces all of the above at the next edge. clk_out may be truncated.
- Period definitions: D=div_act, H=(D+1)>>1. cnt runs 0..D-1 and wraps to 0.
- clk_out=1 for cnt<H, 0 otherwise. Odd D gives one extra high cycle (D=5: 1,1,1,0,0). Counter and all outputs come from one clock domain only.
- rise_tick=1 exactly in cycles with cnt==0 while active. fall_tick=1 exactly in cycles with cnt==H while active.
- Config handshake:
  - Accept when cfg_valid && cfg_ready.
  - If cfg_div < MIN_DIV: reject, cfg_err=1 on the next cycle, no state change.
  - Otherwise store the value in pend_div and set pend_valid=1. cfg_ready=0 while pend_valid=1.
- Applying a pending divisor:
  - Applied on the cycle that loads cnt=0, i.e. at the start of a period or on an IDLE->RUN transition.
  - On apply: div_act<=pend_div and pend_valid<=0. cur_div and cfg_ready update on the same edge.
  - In IDLE, a pending divisor is applied on the next edge even with run=0.
- Simultaneous config and boundary: a divisor accepted in the same cycle as a boundary (cnt==D-1) is not used for the next period. It applies at the following boundary.
- State machine:
  - IDLE: clk_out=0. If run=1: go to RUN, cnt<=0, apply pending if pend_valid was set before this cycle. The first clk_out=1 and rise_tick occur on the cycle after run is first seen high.
  - RUN: cnt advances every cycle. If run=0: go to STOP_PEND, counting continues.
  - STOP_PEND: if run=1, return to RUN with no interruption. If run=0 and cnt==D-1: go to IDLE, cnt<=0, clk_out stays 0. The final period is always completed.
- Divisor change never truncates a period. Every high phase is H cycles and every low phase is D-H cycles of the divisor in effect for that period.
- D=MIN_DIV=2 gives clk_out toggling every cycle (1,0), with rise_tick and fall_tick alternating.

Test Plan:
- Reset then run=1 with DEF_DIV overridden to 4 before start -> clk_out 1,1,0,0 repeating. rise_tick at cnt 0, fall_tick at cnt 2. cur_div=4.
- Running D=4, load cfg_div=5 at cnt=1 -> current period completes as 1,1,0,0, then 1,1,1,0,0. cfg_ready stays 0 until the boundary.
- Load cfg_div=1 -> cfg_err pulses 1 cycle. cur_div, clk_out pattern and cfg_ready=1 are unchanged.
- Running D=6, drop run at cnt=2 -> clk_out finishes 1,0,0,0, then IDLE with active=0 and no extra tick. Repeat with run reasserted at cnt=4 -> continuous pattern, active never drops.
- Accept cfg_div=8 in the cycle where cnt==D-1 (D=4) -> next period still D=4, following period D=8.
- Assert reset at cnt=1 with pend_valid=1 -> next cycle clk_out=0, active=0, cfg_ready=1, cur_div=DEF_DIV, pending discarded.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Run-time clock divider with glitch-free divisor updates
// and clean start/stop sequencing of the divided clock.
module clk_div_ctrl #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 270,
  parameter int MIN_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             active,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_PEND
  } state_t;

  localparam logic [CNT_W-1:0] DEF   = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN   = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_H = (CNT_W+1)'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_act, div_nxt;
  logic [CNT_W-1:0] pend_div, pend_div_nxt;
  logic             pend_valid, pend_nxt;
  logic             err_nxt;
  logic             last, load0, accept;
  logic             act_nxt;
  logic [CNT_W:0]   half_nxt;
  logic [CNT_W:0]   cnt_ext;
  logic             clk_nxt, rise_nxt, fall_nxt;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    div_nxt      = div_act;
    pend_nxt     = pend_valid;
    pend_div_nxt = pend_div;
    err_nxt      = 1'b0;
    load0        = 1'b0;
    last         = (cnt == div_act - ONE_C);
    accept       = cfg_valid && !pend_valid;

    unique case (state)
      IDLE: begin
        load0   = 1'b1;
        cnt_nxt = '0;
        if (run) state_nxt = RUN;
      end
      RUN: begin
        load0   = last;
        cnt_nxt = last ? '0 : cnt + ONE_C;
        if (!run) state_nxt = STOP_PEND;
      end
      STOP_PEND: begin
        load0   = last;
        cnt_nxt = last ? '0 : cnt + ONE_C;
        if (run) state_nxt = RUN;
        else if (last) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // pend_valid blocks accept, so apply and accept never coincide
    if (load0 && pend_valid) begin
      div_nxt  = pend_div;
      pend_nxt = 1'b0;
    end

    if (accept) begin
      if (cfg_div < MIN) begin
        err_nxt = 1'b1;
      end else begin
        pend_nxt     = 1'b1;
        pend_div_nxt = cfg_div;
      end
    end

    act_nxt  = (state_nxt != IDLE);
    half_nxt = ({1'b0, div_nxt} + ONE_H) >> 1;
    cnt_ext  = {1'b0, cnt_nxt};
    clk_nxt  = act_nxt && (cnt_ext < half_nxt);
    rise_nxt = act_nxt && (cnt_nxt == '0);
    fall_nxt = act_nxt && (cnt_ext == half_nxt);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      div_act    <= DEF;
      pend_div   <= '0;
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
      clk_out    <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      div_act    <= div_nxt;
      pend_div   <= pend_div_nxt;
      pend_valid <= pend_nxt;
      cfg_err    <= err_nxt;
      clk_out    <= clk_nxt;
      rise_tick  <= rise_nxt;
      fall_tick  <= fall_nxt;
    end
  end

  assign active    = (state != IDLE);
  assign cfg_ready = !pend_valid;
  assign cur_div   = div_act;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Vector-table and scoreboard bench for clk_div_ctrl,
// built with DEF_DIV=4 so the first periods are short.
module tb_clk_div_ctrl;

  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             reset, run, cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready, cfg_err, clk_out;
  logic             rise_tick, fall_tick, active;
  logic [CNT_W-1:0] cur_div;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl #(
    .CNT_W  (CNT_W),
    .DEF_DIV(4),
    .MIN_DIV(2)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .active   (active),
    .cur_div  (cur_div)
  );

  // exp = {clk_out, rise, fall, active, ready, err, cur_div}
  typedef struct {
    logic        rst;
    logic        run;
    logic        val;
    logic [15:0] div;
    logic [21:0] exp;
  } vec_t;

  vec_t      vecs[$];
  logic [21:0] sb[$];

  function automatic void add(
    input logic rs, input logic rn,
    input logic vl, input int dv,
    input logic c, input logic r, input logic f,
    input logic a, input logic rd, input logic e,
    input int cd
  );
    vec_t t;
    t.rst = rs;
    t.run = rn;
    t.val = vl;
    t.div = 16'(dv);
    t.exp = {c, r, f, a, rd, e, 16'(cd)};
    vecs.push_back(t);
  endfunction

  function automatic logic [21:0] obs();
    return {clk_out, rise_tick, fall_tick,
            active, cfg_ready, cfg_err, cur_div};
  endfunction

  task automatic chk(input string nm,
                     input logic [21:0] want);
    logic [21:0] got;
    got = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%06h want=%06h",
               nm, got, want);
    end
  endtask

  initial begin
    int n;
    int hi;
    bit seen;
    logic [21:0] want;

    reset     = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;

    // rst run v div | clk rise fall act rdy err cur
    add(1,0,0,0, 0,0,0,0,1,0,4);
    add(1,1,0,0, 0,0,0,0,1,0,4);
    // start at D=4: 1,1,0,0
    add(0,1,0,0, 1,1,0,1,1,0,4);
    add(0,1,0,0, 1,0,0,1,1,0,4);
    add(0,1,0,0, 0,0,1,1,1,0,4);
    add(0,1,0,0, 0,0,0,1,1,0,4);
    add(0,1,0,0, 1,1,0,1,1,0,4);
    add(0,1,0,0, 1,0,0,1,1,0,4);
    // offer 5 during cnt=1
    add(0,1,1,5, 0,0,1,1,0,0,4);
    add(0,1,0,0, 0,0,0,1,0,0,4);
    add(0,1,0,0, 1,1,0,1,1,0,5);
    add(0,1,0,0, 1,0,0,1,1,0,5);
    add(0,1,0,0, 1,0,0,1,1,0,5);
    add(0,1,0,0, 0,0,1,1,1,0,5);
    add(0,1,0,0, 0,0,0,1,1,0,5);
    add(0,1,0,0, 1,1,0,1,1,0,5);
    // rejects: 1 and 0
    add(0,1,1,1, 1,0,0,1,1,1,5);
    add(0,1,0,0, 1,0,0,1,1,0,5);
    add(0,1,1,0, 0,0,1,1,1,1,5);
    add(0,1,0,0, 0,0,0,1,1,0,5);
    add(0,1,0,0, 1,1,0,1,1,0,5);
    // switch to 6
    add(0,1,1,6, 1,0,0,1,0,0,5);
    add(0,1,0,0, 1,0,0,1,0,0,5);
    add(0,1,0,0, 0,0,1,1,0,0,5);
    add(0,1,0,0, 0,0,0,1,0,0,5);
    add(0,1,0,0, 1,1,0,1,1,0,6);
    add(0,1,0,0, 1,0,0,1,1,0,6);
    add(0,1,0,0, 1,0,0,1,1,0,6);
    // drop run at cnt=2
    add(0,0,0,0, 0,0,1,1,1,0,6);
    add(0,0,0,0, 0,0,0,1,1,0,6);
    add(0,0,0,0, 0,0,0,1,1,0,6);
    add(0,0,0,0, 0,0,0,0,1,0,6);
    add(0,0,0,0, 0,0,0,0,1,0,6);
    // restart, drop at 2, reassert at 4
    add(0,1,0,0, 1,1,0,1,1,0,6);
    add(0,1,0,0, 1,0,0,1,1,0,6);
    add(0,1,0,0, 1,0,0,1,1,0,6);
    add(0,0,0,0, 0,0,1,1,1,0,6);
    add(0,0,0,0, 0,0,0,1,1,0,6);
    add(0,1,0,0, 0,0,0,1,1,0,6);
    add(0,1,0,0, 1,1,0,1,1,0,6);
    // back to 4
    add(0,1,1,4, 1,0,0,1,0,0,6);
    add(0,1,0,0, 1,0,0,1,0,0,6);
    add(0,1,0,0, 0,0,1,1,0,0,6);
    add(0,1,0,0, 0,0,0,1,0,0,6);
    add(0,1,0,0, 0,0,0,1,0,0,6);
    add(0,1,0,0, 1,1,0,1,1,0,4);
    add(0,1,0,0, 1,0,0,1,1,0,4);
    add(0,1,0,0, 0,0,1,1,1,0,4);
    add(0,1,0,0, 0,0,0,1,1,0,4);
    // offer 8 in the cnt==D-1 cycle
    add(0,1,1,8, 1,1,0,1,0,0,4);
    add(0,1,0,0, 1,0,0,1,0,0,4);
    add(0,1,0,0, 0,0,1,1,0,0,4);
    add(0,1,0,0, 0,0,0,1,0,0,4);
    add(0,1,0,0, 1,1,0,1,1,0,8);
    add(0,1,0,0, 1,0,0,1,1,0,8);
    add(0,1,0,0, 1,0,0,1,1,0,8);
    add(0,1,0,0, 1,0,0,1,1,0,8);
    add(0,1,0,0, 0,0,1,1,1,0,8);
    add(0,1,0,0, 0,0,0,1,1,0,8);
    add(0,1,0,0, 0,0,0,1,1,0,8);
    add(0,1,0,0, 0,0,0,1,1,0,8);
    add(0,1,0,0, 1,1,0,1,1,0,8);
    // pending 2, then reset at cnt=1
    add(0,1,1,2, 1,0,0,1,0,0,8);
    add(1,1,0,0, 0,0,0,0,1,0,4);
    add(0,1,0,0, 1,1,0,1,1,0,4);
    add(0,1,0,0, 1,0,0,1,1,0,4);
    add(0,1,0,0, 0,0,1,1,1,0,4);
    add(0,1,0,0, 0,0,0,1,1,0,4);
    add(0,1,0,0, 1,1,0,1,1,0,4);
    // stop, then load 2 while idle
    add(0,0,0,0, 1,0,0,1,1,0,4);
    add(0,0,0,0, 0,0,1,1,1,0,4);
    add(0,0,0,0, 0,0,0,1,1,0,4);
    add(0,0,0,0, 0,0,0,0,1,0,4);
    add(0,0,1,2, 0,0,0,0,0,0,4);
    add(0,0,0,0, 0,0,0,0,1,0,2);
    // D=2 toggles every cycle
    add(0,1,0,0, 1,1,0,1,1,0,2);
    add(0,1,0,0, 0,0,1,1,1,0,2);
    add(0,1,0,0, 1,1,0,1,1,0,2);
    add(0,1,0,0, 0,0,1,1,1,0,2);

    foreach (vecs[i]) begin
      @(negedge clk_in);
      reset     = vecs[i].rst;
      run       = vecs[i].run;
      cfg_valid = vecs[i].val;
      cfg_div   = vecs[i].div;
      sb.push_back(vecs[i].exp);
      @(posedge clk_in);
      #1;
      want = sb.pop_front();
      chk($sformatf("vec%0d", i), want);
    end

    // switch D=2 -> 3 and measure one full period
    @(negedge clk_in);
    cfg_valid = 1'b1;
    cfg_div   = 16'd3;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk_in);
      #1;
      seen = rise_tick && (cur_div == 16'd3);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL d3_start got=none want=rise");
    end else begin
      n  = 0;
      hi = 0;
      do begin
        if (clk_out) hi++;
        n++;
        @(posedge clk_in);
        #1;
      end while (!rise_tick && n < 20);
      checks++;
      if (n != 3 || hi != 2) begin
        errors++;
        $display("FAIL d3_period got=%0d/%0d want=3/2",
                 n, hi);
      end
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
